multi_tap_echo: RTL and testbench
=================================

MULTI_TAP_ECHO -- requirements
Module: multi_tap_echo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: sample and SRAM word width, signed two's complement.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12: SRAM offset width.
REQ-003 SHALL have parameter TAPS, default 3: number of delay taps, range 1..8.
REQ-004 SHALL have parameter WR_OFFSET, default 1: SRAM offset used for the feedback write.
REQ-005 SHALL have parameter FB_SHIFT, default 1: arithmetic right shift applied to the tap-0 sample in the feedback term.
REQ-006 Ports, in order:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cs  in  1  block select.
- my_turn  in  1  arbitration grant.
- should_save  in  1  request feedback write for this sample.
- data_in  in  DATA_WIDTH  dry sample.
- tap_delay  in  TAPS*ADDR_WIDTH  per-tap read offset; tap i at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- tap_shift  in  TAPS*4  per-tap attenuation shift, 0..15.
- tap_enable  in  TAPS  per-tap enable mask.
- sram_data_in  in  DATA_WIDTH  read data, valid while sram_read_finish is high.
- sram_read_finish  in  1  read complete.
- sram_write_finish  in  1  write complete.
- sram_rd  out  1  one-cycle read request pulse.
- sram_wr  out  1  one-cycle write request pulse.
- sram_offset  out  ADDR_WIDTH  request offset.
- sram_data_out  out  DATA_WIDTH  write data.
- data_out  out  DATA_WIDTH  wet sample.
- available  out  1  high exactly in IDLE.
- done  out  1  high exactly in DONE.

Function
REQ-007 SHALL be a state machine with states IDLE, READ, SAVE and DONE; all outputs SHALL be registered.
REQ-008 In IDLE with cs=1 and my_turn=1, the block SHALL capture data_in, should_save, tap_delay, tap_shift and tap_enable; later input changes SHALL NOT affect the current sample.
REQ-009 On start with any tap enabled, the next edge SHALL enter READ, pulse sram_rd and drive sram_offset to the delay of the lowest enabled tap.
REQ-010 In READ, each edge with sram_read_finish=1 SHALL add (sram_data_in >>> tap_shift[i]) to the accumulator, using sign-extended arithmetic.
REQ-011 After a READ accumulation, if a higher enabled tap remains, that same edge SHALL pulse sram_rd with that tap's delay; taps SHALL be read in ascending index, and disabled taps SHALL be skipped.
REQ-012 The accumulator SHALL be DATA_WIDTH+4 bits wide and SHALL be cleared on every start.
REQ-013 After the last tap, result = data_in + accumulator, narrowed per REQ-022; with the captured should_save=0, that edge SHALL load data_out and enter DONE.
REQ-014 With the captured should_save=1, that edge SHALL instead pulse sram_wr, set sram_offset=WR_OFFSET and sram_data_out = data_in + (tap0 sample >>> FB_SHIFT), narrowed per REQ-022, load data_out, and enter SAVE.
REQ-015 If tap 0 is disabled, the feedback term SHALL be zero.
REQ-016 In SAVE, sram_write_finish=1 SHALL move the block to DONE.
REQ-017 DONE SHALL last exactly one cycle and then return to IDLE.
REQ-018 On start with tap_enable all zero, the block SHALL enter DONE, or SAVE if should_save=1, with data_out=data_in and no sram_rd.
REQ-019 sram_read_finish outside READ and sram_write_finish outside SAVE SHALL be ignored.
REQ-020 sram_rd and sram_wr SHALL never be high in the same cycle.
REQ-021 data_out, sram_offset and sram_data_out SHALL hold their values until next updated.

Reset
REQ-022 (narrowing) With ECHO_SATURATE_EN defined, results SHALL clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]; otherwise they SHALL keep the low DATA_WIDTH bits (wrap).
REQ-023 With rst=0 at a rising edge, from any state, the block SHALL enter IDLE and clear data_out, sram_rd, sram_wr, sram_offset, sram_data_out and the accumulator.
REQ-024 An in-flight SRAM transaction aborted by reset SHALL be abandoned; its late finish strobe SHALL be ignored per REQ-019.

Configuration
REQ-025 The macro ECHO_SATURATE_EN SHALL select saturating narrowing when defined and wrapping narrowing when undefined.
REQ-026 This macro SHALL be the only compile-time feature switch.

Verification (DATA_WIDTH=16, TAPS=3, delays 2048/1024/512, shifts 1/2/3, FB_SHIFT=1)
REQ-027 All taps enabled, data_in=0x1000, each read returns 0x0800, should_save=0 -> sram_rd pulses at offsets 2048, 1024 and 512 in order; data_out=0x1700; one done pulse.
REQ-028 data_in=0x7000, each read returns 0x7FFF -> data_out=0x7FFF with ECHO_SATURATE_EN; data_out=0xDFFD without it.
REQ-029 Only tap 0 enabled, data_in=0xF000, read returns 0x8000 -> data_out=0xB000.
REQ-030 should_save=1, only tap 0 enabled, data_in=0x0100, read returns 0x0400 -> sram_wr pulse at offset 1 with data 0x0300; done only on the cycle after sram_write_finish.
REQ-031 tap_enable=0, should_save=0 -> no sram_rd; data_out=data_in; done 2 cycles after the start edge.
REQ-032 rst=0 in READ, then sram_read_finish after release -> IDLE, outputs zero, strobe ignored, available=1.

Source files
------------

// File: rtl/multi_tap_echo.sv
// rtl/multi_tap_echo.sv - multi-tap SRAM echo with optional feedback write
// Compile-time switch: ECHO_SATURATE_EN selects saturating result narrowing (wrap when undefined).
module multi_tap_echo #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int TAPS       = 3,
  parameter int WR_OFFSET  = 1,
  parameter int FB_SHIFT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cs,
  input  logic                       my_turn,
  input  logic                       should_save,
  input  logic [DATA_WIDTH-1:0]      data_in,
  input  logic [TAPS*ADDR_WIDTH-1:0] tap_delay,
  input  logic [TAPS*4-1:0]          tap_shift,
  input  logic [TAPS-1:0]            tap_enable,
  input  logic [DATA_WIDTH-1:0]      sram_data_in,
  input  logic                       sram_read_finish,
  input  logic                       sram_write_finish,
  output logic                       sram_rd,
  output logic                       sram_wr,
  output logic [ADDR_WIDTH-1:0]      sram_offset,
  output logic [DATA_WIDTH-1:0]      sram_data_out,
  output logic [DATA_WIDTH-1:0]      data_out,
  output logic                       available,
  output logic                       done
);

  localparam int ACC_W = DATA_WIDTH + 4;
  localparam int RES_W = DATA_WIDTH + 5;
  localparam logic [ADDR_WIDTH-1:0] WR_OFF = ADDR_WIDTH'(WR_OFFSET);

  typedef enum logic [1:0] {IDLE, READ, SAVE, DONE} state_t;
  state_t state, state_nxt;

  // Sample context frozen at start so later input changes cannot disturb it
  logic [DATA_WIDTH-1:0]      cap_data;
  logic                       cap_save;
  logic [TAPS*ADDR_WIDTH-1:0] cap_delay;
  logic [TAPS*4-1:0]          cap_shift;
  logic [TAPS-1:0]            cap_en;

  logic signed [ACC_W-1:0] acc, acc_nxt, rd_sext, rd_term, acc_sum;
  logic [DATA_WIDTH-1:0]   tap0, tap0_nxt, tap0_src;
  logic [3:0]              cur, cur_nxt, first_idx, nxt_idx;
  logic                    first_found, nxt_found, start;
  logic [3:0]              cur_shift;
  logic signed [RES_W-1:0] result, fb, t0_ext, data_ext;

  logic                    rd_nxt, wr_nxt;
  logic [ADDR_WIDTH-1:0]   offset_nxt;
  logic [DATA_WIDTH-1:0]   sdo_nxt, dout_nxt;

  // Fold a wide signed result back to DATA_WIDTH
  function automatic logic [DATA_WIDTH-1:0] narrow(input logic signed [RES_W-1:0] v);
`ifdef ECHO_SATURATE_EN
    logic signed [RES_W-1:0] hi, lo;
    hi = {{(RES_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    lo = ~hi;
    if (v > hi)      narrow = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    else if (v < lo) narrow = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else             narrow = DATA_WIDTH'(v);
`else
    narrow = DATA_WIDTH'(v);
`endif
  endfunction

  assign start     = cs && my_turn;
  assign rd_sext   = {{4{sram_data_in[DATA_WIDTH-1]}}, sram_data_in};
  assign cur_shift = cap_shift[cur*4 +: 4];
  assign rd_term   = rd_sext >>> cur_shift;
  assign acc_sum   = acc + rd_term;
  assign data_ext  = {{5{cap_data[DATA_WIDTH-1]}}, cap_data};
  assign result    = data_ext + {acc_sum[ACC_W-1], acc_sum};
  // When tap 0 is the last read, its sample is still on the SRAM bus
  assign tap0_src  = (cur == 4'd0) ? sram_data_in : tap0;
  assign t0_ext    = {{5{tap0_src[DATA_WIDTH-1]}}, tap0_src};
  assign fb        = data_ext + (t0_ext >>> FB_SHIFT);

  // Lowest enabled tap of the incoming mask, used for the first read
  always_comb begin
    first_found = 1'b0;
    first_idx   = 4'd0;
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (tap_enable[i]) begin
        first_found = 1'b1;
        first_idx   = 4'(i);
      end
    end
  end

  // Next enabled tap above the one being read; disabled taps are skipped
  always_comb begin
    nxt_found = 1'b0;
    nxt_idx   = 4'd0;
    for (int i = TAPS - 1; i >= 0; i--) begin
      if (cap_en[i] && (i > int'(cur))) begin
        nxt_found = 1'b1;
        nxt_idx   = 4'(i);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) begin
        if (first_found)      state_nxt = READ;
        else if (should_save) state_nxt = SAVE;
        else                  state_nxt = DONE;
      end
      READ: if (sram_read_finish && !nxt_found) state_nxt = cap_save ? SAVE : DONE;
      SAVE: if (sram_write_finish) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values for the registered outputs and datapath
  always_comb begin
    rd_nxt     = 1'b0;
    wr_nxt     = 1'b0;
    offset_nxt = sram_offset;
    sdo_nxt    = sram_data_out;
    dout_nxt   = data_out;
    acc_nxt    = acc;
    tap0_nxt   = tap0;
    cur_nxt    = cur;
    case (state)
      IDLE: if (start) begin
        acc_nxt  = '0;
        tap0_nxt = '0;
        cur_nxt  = first_idx;
        if (first_found) begin
          rd_nxt     = 1'b1;
          offset_nxt = tap_delay[first_idx*ADDR_WIDTH +: ADDR_WIDTH];
        end else begin
          dout_nxt = data_in;
          if (should_save) begin
            wr_nxt     = 1'b1;
            offset_nxt = WR_OFF;
            sdo_nxt    = data_in;
          end
        end
      end
      READ: if (sram_read_finish) begin
        acc_nxt = acc_sum;
        if (cur == 4'd0) tap0_nxt = sram_data_in;
        if (nxt_found) begin
          rd_nxt     = 1'b1;
          offset_nxt = cap_delay[nxt_idx*ADDR_WIDTH +: ADDR_WIDTH];
          cur_nxt    = nxt_idx;
        end else begin
          dout_nxt = narrow(result);
          if (cap_save) begin
            wr_nxt     = 1'b1;
            offset_nxt = WR_OFF;
            sdo_nxt    = narrow(fb);
          end
        end
      end
      default: ;
    endcase
  end

  // Output, capture and accumulator registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      cap_data      <= '0;
      cap_save      <= 1'b0;
      cap_delay     <= '0;
      cap_shift     <= '0;
      cap_en        <= '0;
      acc           <= '0;
      tap0          <= '0;
      cur           <= 4'd0;
      sram_rd       <= 1'b0;
      sram_wr       <= 1'b0;
      sram_offset   <= '0;
      sram_data_out <= '0;
      data_out      <= '0;
      available     <= 1'b1;
      done          <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        cap_data  <= data_in;
        cap_save  <= should_save;
        cap_delay <= tap_delay;
        cap_shift <= tap_shift;
        cap_en    <= tap_enable;
      end
      acc           <= acc_nxt;
      tap0          <= tap0_nxt;
      cur           <= cur_nxt;
      sram_rd       <= rd_nxt;
      sram_wr       <= wr_nxt;
      sram_offset   <= offset_nxt;
      sram_data_out <= sdo_nxt;
      data_out      <= dout_nxt;
      available     <= (state_nxt == IDLE);
      done          <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_multi_tap_echo.sv
// tb/tb_multi_tap_echo.sv - directed scoreboard bench for multi_tap_echo
module tb_multi_tap_echo;

  localparam int DW   = 16;
  localparam int AW   = 12;
  localparam int TAPS = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, cs, my_turn, should_save;
  logic [DW-1:0]        data_in, sram_data_in;
  logic [TAPS*AW-1:0]   tap_delay;
  logic [TAPS*4-1:0]    tap_shift;
  logic [TAPS-1:0]      tap_enable;
  logic                 sram_read_finish, sram_write_finish;
  logic                 sram_rd, sram_wr, available, done;
  logic [AW-1:0]        sram_offset;
  logic [DW-1:0]        sram_data_out, data_out;

  int checks   = 0;
  int failures = 0;

  logic [AW-1:0]    rd_q[$];
  logic [DW-1:0]    out_q[$];
  logic [AW+DW-1:0] wr_q[$];

  multi_tap_echo #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAPS(TAPS), .WR_OFFSET(1), .FB_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .cs(cs), .my_turn(my_turn), .should_save(should_save),
    .data_in(data_in), .tap_delay(tap_delay), .tap_shift(tap_shift), .tap_enable(tap_enable),
    .sram_data_in(sram_data_in), .sram_read_finish(sram_read_finish),
    .sram_write_finish(sram_write_finish), .sram_rd(sram_rd), .sram_wr(sram_wr),
    .sram_offset(sram_offset), .sram_data_out(sram_data_out), .data_out(data_out),
    .available(available), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] narrow(input int v);
`ifdef ECHO_SATURATE_EN
    if (v > 32767) return 16'h7FFF;
    if (v < -32768) return 16'h8000;
`endif
    return v[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] model_out(input logic [DW-1:0] din, input logic [TAPS-1:0] en,
                                              input logic [DW-1:0] rdv);
    int acc, s, d;
    acc = 0;
    s = $signed(rdv);
    d = $signed(din);
    for (int i = 0; i < TAPS; i++)
      if (en[i]) acc += s >>> int'(tap_shift[i*4 +: 4]);
    return narrow(d + acc);
  endfunction

  function automatic logic [DW-1:0] model_fb(input logic [DW-1:0] din, input logic [TAPS-1:0] en,
                                             input logic [DW-1:0] rdv);
    int s, d;
    s = $signed(rdv);
    d = $signed(din);
    return narrow(d + (en[0] ? (s >>> 1) : 0));
  endfunction

  task automatic run_job(input string name, input logic [DW-1:0] din, input logic save,
                         input logic [TAPS-1:0] en, input logic [DW-1:0] rdv,
                         input logic [DW-1:0] exp_out, input logic [DW-1:0] exp_fb,
                         input int max_lat);
    int cyc, done_at, wr_at, done_cnt;
    bit both;
    rd_q.delete(); out_q.delete(); wr_q.delete();
    for (int i = 0; i < TAPS; i++)
      if (en[i]) rd_q.push_back(tap_delay[i*AW +: AW]);
    out_q.push_back(exp_out);
    if (save) wr_q.push_back({AW'(1), exp_fb});
    @(negedge clk);
    cs = 1'b1; my_turn = 1'b1; data_in = din; should_save = save; tap_enable = en;
    sram_data_in = rdv;
    @(negedge clk);
    cs = 1'b0; my_turn = 1'b0; data_in = ~din; should_save = ~save; tap_enable = ~en;
    done_at = 0; wr_at = 0; done_cnt = 0; both = 1'b0;
    cyc = 1;
    while (cyc <= 40) begin
      sram_read_finish = 1'b0;
      sram_write_finish = 1'b0;
      if (sram_rd && sram_wr) both = 1'b1;
      if (sram_rd) begin
        check({name, " rd_expected"}, 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check({name, " rd_offset"}, sram_offset, rd_q.pop_front());
        sram_read_finish = 1'b1;
        sram_write_finish = 1'b1;
      end
      if (sram_wr) begin
        wr_at = cyc;
        check({name, " wr_expected"}, 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) check({name, " wr_offset_data"}, {sram_offset, sram_data_out}, wr_q.pop_front());
        sram_write_finish = 1'b1;
        sram_read_finish = 1'b1;
      end
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          done_at = cyc;
          check({name, " data_out"}, data_out, out_q.pop_front());
          check({name, " avail_in_done"}, available, 0);
        end
      end else if (done_cnt > 0) begin
        check({name, " done_single"}, done, 0);
        check({name, " idle_avail"}, available, 1);
        check({name, " data_hold"}, data_out, exp_out);
        break;
      end
      @(negedge clk);
      cyc++;
    end
    sram_read_finish = 1'b0;
    sram_write_finish = 1'b0;
    check({name, " done_count"}, done_cnt, 1);
    check({name, " reads_left"}, rd_q.size(), 0);
    check({name, " writes_left"}, wr_q.size(), 0);
    check({name, " rd_wr_overlap"}, 32'(both), 0);
    if (save) check({name, " done_after_wr"}, 32'(done_at == wr_at + 1), 1);
    if (max_lat > 0) check({name, " done_latency"}, 32'(done_at >= 1 && done_at <= max_lat), 1);
  endtask

  initial begin
    logic [DW-1:0] rdin, rdv;
    rst = 1'b0; cs = 1'b0; my_turn = 1'b0; should_save = 1'b0; data_in = '0;
    tap_delay = {12'd512, 12'd1024, 12'd2048};
    tap_shift = {4'd3, 4'd2, 4'd1};
    tap_enable = '0; sram_data_in = '0; sram_read_finish = 1'b0; sram_write_finish = 1'b0;
    repeat (2) @(negedge clk);
    check("reset available", available, 1);
    check("reset done", done, 0);
    check("reset data_out", data_out, 0);
    check("reset offset", sram_offset, 0);
    check("reset rd_wr", {sram_rd, sram_wr}, 0);
    rst = 1'b1;

    run_job("three_taps", 16'h1000, 1'b0, 3'b111, 16'h0800, 16'h1700, 16'h0000, 0);
`ifdef ECHO_SATURATE_EN
    run_job("overflow", 16'h7000, 1'b0, 3'b111, 16'h7FFF, 16'h7FFF, 16'h0000, 0);
`else
    run_job("overflow", 16'h7000, 1'b0, 3'b111, 16'h7FFF, 16'hDFFD, 16'h0000, 0);
`endif
    run_job("tap0_negative", 16'hF000, 1'b0, 3'b001, 16'h8000, 16'hB000, 16'h0000, 0);
    run_job("no_taps", 16'h4321, 1'b0, 3'b000, 16'h7777, 16'h4321, 16'h0000, 2);
    run_job("save_tap0", 16'h0100, 1'b1, 3'b001, 16'h0400, 16'h0300, 16'h0300, 0);
    run_job("save_no_taps", 16'h1234, 1'b1, 3'b000, 16'h5555, 16'h1234, 16'h1234, 0);
    rdin = 16'($urandom_range(0, 16'hFFFF));
    rdv  = 16'($urandom_range(0, 16'hFFFF));
    run_job("rand_skip_tap1", rdin, 1'b1, 3'b101, rdv, model_out(rdin, 3'b101, rdv),
            model_fb(rdin, 3'b101, rdv), 0);
    rdin = 16'($urandom_range(0, 16'hFFFF));
    rdv  = 16'($urandom_range(0, 16'hFFFF));
    run_job("rand_no_tap0", rdin, 1'b1, 3'b110, rdv, model_out(rdin, 3'b110, rdv),
            model_fb(rdin, 3'b110, rdv), 0);

    @(negedge clk);
    cs = 1'b1; my_turn = 1'b1; data_in = 16'h2222; should_save = 1'b0; tap_enable = 3'b111;
    @(negedge clk);
    cs = 1'b0; my_turn = 1'b0;
    check("abort in_read_rd", sram_rd, 1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sram_read_finish = 1'b1; sram_data_in = 16'h7FFF;
    check("abort data_out", data_out, 0);
    check("abort offset", sram_offset, 0);
    check("abort sram_data_out", sram_data_out, 0);
    check("abort rd_wr", {sram_rd, sram_wr}, 0);
    check("abort available", available, 1);
    @(negedge clk);
    sram_read_finish = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("abort stray_rd", sram_rd, 0);
      check("abort stray_done", done, 0);
      check("abort stray_avail", available, 1);
      check("abort stray_data", data_out, 0);
      @(negedge clk);
    end

    run_job("after_abort", 16'h1000, 1'b0, 3'b111, 16'h0800, 16'h1700, 16'h0000, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
